mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared DEPTH:1 word mux.
- DEPTH requesters compete for the mux; the block drives the mux select and a one-hot grant, and presents a valid/ready handshake toward the mux consumer.
- Acknowledges each requester per accepted beat.
- Sits directly in front of the mux select input; owns all sequencing of it.

---
 rtl/mux_rr_arbiter_if.sv | 23 ++
 rtl/mux_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter and the requester/consumer side.
// master = arbiter (drives select, grant, valid, ack); slave = requesters and consumer.
interface mux_rr_arbiter_if #(
  parameter int DEPTH             = 16,
  parameter int SELECT_LINE_DEPTH = 4
);
  logic [DEPTH-1:0]             req;
  logic                         out_ready;
  logic [SELECT_LINE_DEPTH-1:0] s;
  logic [DEPTH-1:0]             gnt;
  logic                         out_valid;
  logic [DEPTH-1:0]             ack;

  modport master (
    input  req, out_ready,
    output s, gnt, out_valid, ack
  );

  modport slave (
    output req, out_ready,
    input  s, gnt, out_valid, ack
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer owning the select of a DEPTH:1 word mux.
// Optional macro MUX_ARB_BURST_EN lets a grantee keep the mux for up to MAX_BURST beats.
//
// state | meaning
// IDLE  | no beat presented; gnt=0, out_valid=0, s holds its last value
// BUSY  | beat from requester s presented to the consumer, waiting for out_ready
module mux_rr_arbiter #(
  parameter int WIDTH             = 32,
  parameter int DEPTH             = 16,
  parameter int SELECT_LINE_DEPTH = 4,
  parameter int MAX_BURST         = 4
) (
  input logic               clk,
  input logic               rst,
  mux_rr_arbiter_if.master  arb
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                       state, nxt_state;
  logic [SELECT_LINE_DEPTH-1:0] s_q, nxt_s;
  logic [SELECT_LINE_DEPTH-1:0] last_q, nxt_last;
  logic [DEPTH-1:0]             gnt_q, nxt_gnt;
  logic                         valid_q, nxt_valid;

  logic                         accept;
  logic                         found;
  logic [SELECT_LINE_DEPTH-1:0] win;
  logic [SELECT_LINE_DEPTH-1:0] search_idx;
  logic                         keep;

`ifdef MUX_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_q, nxt_cnt;
`endif

  assign accept = valid_q & arb.out_ready;

  // Search starts just past the last grantee, so the previous winner ranks lowest.
  always_comb begin
    found      = 1'b0;
    win        = '0;
    search_idx = last_q;
    for (int i = 0; i < DEPTH; i++) begin
      search_idx = (search_idx == SELECT_LINE_DEPTH'(DEPTH - 1)) ? '0 : search_idx + 1'b1;
      if (!found && arb.req[search_idx]) begin
        found = 1'b1;
        win   = search_idx;
      end
    end
  end

`ifdef MUX_ARB_BURST_EN
  assign keep = accept && arb.req[s_q] && ((int'(cnt_q) + 1) < MAX_BURST);
`else
  assign keep = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      s_q     <= '0;
      last_q  <= SELECT_LINE_DEPTH'(DEPTH - 1);
      gnt_q   <= '0;
      valid_q <= 1'b0;
`ifdef MUX_ARB_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state   <= nxt_state;
      s_q     <= nxt_s;
      last_q  <= nxt_last;
      gnt_q   <= nxt_gnt;
      valid_q <= nxt_valid;
`ifdef MUX_ARB_BURST_EN
      cnt_q   <= nxt_cnt;
`endif
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (found) nxt_state = BUSY;
      BUSY:    if (accept && !keep && !found) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    nxt_s     = s_q;
    nxt_last  = last_q;
    nxt_gnt   = gnt_q;
    nxt_valid = valid_q;
`ifdef MUX_ARB_BURST_EN
    nxt_cnt   = cnt_q;
`endif
    if (keep) begin
`ifdef MUX_ARB_BURST_EN
      nxt_cnt = cnt_q + 1'b1;
`endif
    end else if ((state == IDLE || accept) && found) begin
      nxt_s     = win;
      nxt_last  = win;
      nxt_gnt   = DEPTH'(1) << win;
      nxt_valid = 1'b1;
`ifdef MUX_ARB_BURST_EN
      nxt_cnt   = '0;
`endif
    end else if (state == BUSY && accept) begin
      nxt_gnt   = '0;
      nxt_valid = 1'b0;
`ifdef MUX_ARB_BURST_EN
      nxt_cnt   = '0;
`endif
    end
  end

  assign arb.s         = s_q;
  assign arb.gnt       = gnt_q;
  assign arb.out_valid = valid_q;
  assign arb.ack       = gnt_q & {DEPTH{valid_q & arb.out_ready}};

  // A presented beat always carries exactly one grant; the parameter terms catch bad instantiation.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst)
    valid_q |-> ($onehot(gnt_q) && (WIDTH > 0) && (DEPTH <= 2**SELECT_LINE_DEPTH) && (MAX_BURST >= 1)));

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a driver keeps per-requester word counts and a
// round-robin reference model that queues expected grants; a monitor pops them on each beat.
module tb_mux_rr_arbiter;
  localparam int DEPTH     = 16;
  localparam int SLD       = 4;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst;

  mux_rr_arbiter_if #(.DEPTH(DEPTH), .SELECT_LINE_DEPTH(SLD)) bus ();

  mux_rr_arbiter #(
    .WIDTH(32), .DEPTH(DEPTH), .SELECT_LINE_DEPTH(SLD), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int pending[DEPTH];
  int exp_q[$];
  bit m_busy;
  int m_w;
  int m_last;
  int last_exp_s;
`ifdef MUX_ARB_BURST_EN
  int m_cnt;
`endif

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_busy     = 1'b0;
    m_w        = 0;
    m_last     = DEPTH - 1;
    last_exp_s = 0;
`ifdef MUX_ARB_BURST_EN
    m_cnt      = 0;
`endif
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) pending[i] = 0;
  endfunction

  // One clock of stimulus; the requester whose beat is accepted retires one word.
  task automatic step(input bit rdy);
    bit acc, found, kept;
    int win;
    logic [DEPTH-1:0] cur;
    @(negedge clk);
    acc = m_busy && rdy;
    if (acc) pending[m_w]--;
    cur = '0;
    for (int i = 0; i < DEPTH; i++) cur[i] = (pending[i] > 0);
    bus.req       = cur;
    bus.out_ready = rdy;
    if (!m_busy || acc) begin
      kept = 1'b0;
`ifdef MUX_ARB_BURST_EN
      if (acc && cur[m_w] && (m_cnt + 1 < MAX_BURST)) begin
        kept = 1'b1;
        m_cnt++;
        exp_q.push_back(m_w);
      end
`endif
      if (!kept) begin
        found = 1'b0;
        win   = 0;
        for (int k = 1; k <= DEPTH; k++) begin
          if (!found && cur[(m_last + k) % DEPTH]) begin
            found = 1'b1;
            win   = (m_last + k) % DEPTH;
          end
        end
        if (found) begin
          m_w    = win;
          m_last = win;
          m_busy = 1'b1;
`ifdef MUX_ARB_BURST_EN
          m_cnt  = 0;
`endif
          exp_q.push_back(win);
        end else if (acc) begin
          m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(rdy);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst           = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compares every cycle against the head of the expected-grant queue.
  initial begin
    int w;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_gnt", int'(bus.gnt), 0);
        chk("reset_ack", int'(bus.ack), 0);
        chk("reset_s", int'(bus.s), 0);
      end else if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_valid", 1, 0);
        end else begin
          w = exp_q[0];
          chk("beat_s", int'(bus.s), w);
          chk("beat_gnt", int'(bus.gnt), 1 << w);
          chk("beat_ack", int'(bus.ack), bus.out_ready ? (1 << w) : 0);
          if (!bus.out_ready) chk("protocol_req_held", int'(bus.req[w]), 1);
          last_exp_s = w;
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_gnt", int'(bus.gnt), 0);
        chk("idle_ack", int'(bus.ack), 0);
        chk("idle_s_hold", int'(bus.s), last_exp_s);
      end
    end
  end

  initial begin
    int guard;
    bit done;
    rst           = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run(2, 1'b1);

    // Single requester streaming words back to back.
    pending[0] = 6;
    run(10, 1'b1);

    // All requesters busy: full rotation twice.
    for (int i = 0; i < DEPTH; i++) pending[i] = 2;
    run(2 * DEPTH + 4, 1'b1);

    // Consumer stalls five cycles with requesters 2 and 5 pending; then 5 leaves and s holds.
    pending[2] = 1;
    pending[5] = 1;
    step(1'b0);
    run(5, 1'b0);
    run(2, 1'b1);
    run(3, 1'b0);

    // Reset while busy, then requesters 15 and 0 race: 0 must win.
    for (int i = 0; i < DEPTH; i++) pending[i] = 3;
    run(3, 1'b1);
    pulse_reset();
    pending[15] = 1;
    pending[0]  = 1;
    run(5, 1'b1);

    // Randomized arrivals and consumer backpressure.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < DEPTH; i++)
        if ($urandom_range(99) < 12) pending[i] += 1;
      step($urandom_range(3) != 0);
    end

    // Drain with a bounded cycle budget.
    done = 1'b0;
    for (guard = 0; guard < 4000 && !done; guard++) begin
      step(1'b1);
      done = !m_busy;
      for (int i = 0; i < DEPTH; i++) if (pending[i] != 0) done = 1'b0;
    end
    chk("drain_within_budget", int'(done), 1);
    run(3, 1'b1);
    @(negedge clk);
    #3;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
